quad_root_stream: RTL and testbench

- Pipelined monic quadratic solver x^2 + b*x + c = 0 for the multi-antenna DoA chain; successor to the 2-antenna root block.
- Adds a channel tag pass-through, ready/valid backpressure, complex-root output (real/imag) instead of discarding negative discriminants, and saturating outputs with flags.
- Sits between the covariance/coefficient stage and the angle LUT.

---
 rtl/quad_pkg.sv | 59 +++++
 rtl/sqrt_lut_ce.sv | 40 ++++
 rtl/quad_root_stream.sv | 209 ++++++++++++++++++++
 tb/tb_quad_root_stream.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quad_root_stream pipeline.
//   - default widths / binary points of the coefficient, sqrt LUT and output formats
//   - PIPE_LAT: accept-to-output latency in enabled cycles
//   - sat_int: clamp a signed value to a signed range of a given bit width
//   - sqrt_entry: contents of one sqrt LUT word, evaluated at elaboration
package quad_pkg;

    localparam int unsigned DEF_DIN_WIDTH      = 16;
    localparam int unsigned DEF_DIN_POINT      = 14;
    localparam int unsigned DEF_SQRT_IN_WIDTH  = 10;
    localparam int unsigned DEF_SQRT_IN_POINT  = 7;
    localparam int unsigned DEF_SQRT_OUT_WIDTH = 8;
    localparam int unsigned DEF_SQRT_OUT_POINT = 5;
    localparam int unsigned DEF_DOUT_WIDTH     = 10;
    localparam int unsigned DEF_DOUT_POINT     = 6;
    localparam int unsigned DEF_TAG_WIDTH      = 4;

    localparam int unsigned PIPE_LAT = 6;

    // Clamp value into [-2^(width-1), 2^(width-1)-1].
    function automatic int sat_int(input int value, input int unsigned width);
        int hi;
        int lo;
        hi = (1 <<< (width - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // floor(sqrt(addr / 2^in_point) * 2^out_point), clamped to out_width bits.
    // Computed as isqrt(addr scaled by 2^(2*out_point - in_point)).
    function automatic int unsigned sqrt_entry(input int unsigned addr,
                                               input int unsigned in_point,
                                               input int unsigned out_width,
                                               input int unsigned out_point);
        int          shift;
        int unsigned v;
        int unsigned r;
        int unsigned t;
        int unsigned top;
        shift = 2 * int'(out_point) - int'(in_point);
        v     = (shift >= 0) ? (addr << shift) : (addr >> (-shift));
        r     = 0;
        for (int k = 15; k >= 0; k--) begin
            t = r | (32'd1 << k);
            if (t * t <= v) begin
                r = t;
            end
        end
        top = (32'd1 << out_width) - 1;
        return (r > top) ? top : r;
    endfunction

endpackage

// File: rtl/sqrt_lut_ce.sv
// Unsigned square-root lookup with a registered, clock-enabled read.
// The table is built at elaboration from quad_pkg::sqrt_entry, so no init file is needed.
//   clk, rst : clock, async active-high reset (clears the read register)
//   ce       : read register loads only when high
//   addr     : IN_WIDTH-bit unsigned input, IN_POINT fractional bits
//   data     : OUT_WIDTH-bit unsigned sqrt, OUT_POINT fractional bits, valid one enabled cycle later
module sqrt_lut_ce
    import quad_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_SQRT_IN_WIDTH,
    parameter int unsigned IN_POINT  = DEF_SQRT_IN_POINT,
    parameter int unsigned OUT_WIDTH = DEF_SQRT_OUT_WIDTH,
    parameter int unsigned OUT_POINT = DEF_SQRT_OUT_POINT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [IN_WIDTH-1:0]  addr,
    output logic [OUT_WIDTH-1:0] data
);

    localparam int unsigned DEPTH = 1 << IN_WIDTH;

    logic [OUT_WIDTH-1:0] rom [DEPTH];

    // Constant table contents.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = OUT_WIDTH'(sqrt_entry(i, IN_POINT, OUT_WIDTH, OUT_POINT));
    end

    // Registered read, frozen while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (ce) begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/quad_root_stream.sv
// Pipelined monic quadratic solver x^2 + b*x + c = 0 with ready/valid flow control.
// Real roots -h +/- sqrt(D), or complex pair -h +/- j*sqrt(-D), with h = b/2, D = h^2 - c.
//   clk, rst     : clock, async active-high reset (flushes all in-flight samples)
//   b, c         : signed coefficients, DIN_POINT fractional bits
//   din_tag      : channel tag carried alongside the sample
//   din_valid    : input valid;  din_ready : input accepted when both high (combinational)
//   x1, x2       : roots (real case) or real part (complex case), DOUT_POINT fractional bits
//   x_imag       : +sqrt(-D) for complex roots, 0 otherwise
//   dout_tag     : tag of the presented sample
//   dout_complex : D < 0;  dout_sat : sqrt input clipped or any output saturated
//   dout_valid   : output valid;  dout_ready : downstream accept
module quad_root_stream
    import quad_pkg::*;
#(
    parameter int unsigned DIN_WIDTH      = DEF_DIN_WIDTH,
    parameter int unsigned DIN_POINT      = DEF_DIN_POINT,
    parameter int unsigned SQRT_IN_WIDTH  = DEF_SQRT_IN_WIDTH,
    parameter int unsigned SQRT_IN_POINT  = DEF_SQRT_IN_POINT,
    parameter int unsigned SQRT_OUT_WIDTH = DEF_SQRT_OUT_WIDTH,
    parameter int unsigned SQRT_OUT_POINT = DEF_SQRT_OUT_POINT,
    parameter int unsigned DOUT_WIDTH     = DEF_DOUT_WIDTH,
    parameter int unsigned DOUT_POINT     = DEF_DOUT_POINT,
    parameter int unsigned TAG_WIDTH      = DEF_TAG_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  b,
    input  logic signed [DIN_WIDTH-1:0]  c,
    input  logic [TAG_WIDTH-1:0]         din_tag,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic signed [DOUT_WIDTH-1:0] x1,
    output logic signed [DOUT_WIDTH-1:0] x2,
    output logic signed [DOUT_WIDTH-1:0] x_imag,
    output logic [TAG_WIDTH-1:0]         dout_tag,
    output logic                         dout_complex,
    output logic                         dout_sat,
    output logic                         dout_valid,
    input  logic                         dout_ready
);

    localparam int unsigned H2_WIDTH    = 2 * DIN_WIDTH;
    localparam int unsigned H2_POINT    = 2 * DIN_POINT + 2;
    localparam int unsigned C_SHIFT     = DIN_POINT + 2;
    localparam int unsigned D_WIDTH     = H2_WIDTH + 1;
    localparam int unsigned D_POINT     = H2_POINT;
    localparam int unsigned SQRT_IN_INT = SQRT_IN_WIDTH - SQRT_IN_POINT;
    localparam int unsigned NEGH_WIDTH  = DIN_WIDTH + 1;
    localparam int unsigned NEGH_POINT  = DIN_POINT + 1;
    localparam int unsigned SUM_WIDTH   = DOUT_WIDTH + 2;
    localparam int          H_SHIFT     = int'(NEGH_POINT) - int'(DOUT_POINT);
    localparam int          S_SHIFT     = int'(DOUT_POINT) - int'(SQRT_OUT_POINT);

    logic en_c;

    // Stage valids S1..S5; dout_valid is the sixth.
    logic [PIPE_LAT-2:0] vld;

    logic signed [DIN_WIDTH-1:0] s1_b, s1_c, s2_b, s3_b, s4_b, s5_b;
    logic [TAG_WIDTH-1:0]        s1_tag, s2_tag, s3_tag, s4_tag, s5_tag;
    logic signed [H2_WIDTH-1:0]  s2_h2, s2_cal;
    logic signed [D_WIDTH-1:0]   s3_d;
    logic [SQRT_IN_WIDTH-1:0]    s4_addr;
    logic                        s4_neg, s4_sat, s5_neg, s5_sat;
    logic [SQRT_OUT_WIDTH-1:0]   s5_s;

    logic [D_WIDTH-1:0]          mag_c;
    logic                        mag_ovf_c;
    logic [SQRT_IN_WIDTH-1:0]    addr_c;

    logic signed [NEGH_WIDTH-1:0] negh_c;
    logic signed [SUM_WIDTH-1:0]  negh_al, s_al, sum_p, sum_m;
    int                           h_i, s_i, p_i, m_i, h_q, s_q, p_q, m_q;
    logic signed [DOUT_WIDTH-1:0] x1_c, x2_c, xi_c;
    logic                         clip_c;

    // Global advance: free slot at the output or downstream taking it.
    assign en_c      = ~dout_valid | dout_ready;
    assign din_ready = en_c;

    // |D| mapped onto the LUT address; integer part too wide forces all ones.
    assign mag_c     = s3_d[D_WIDTH-1] ? D_WIDTH'($unsigned(-s3_d)) : D_WIDTH'($unsigned(s3_d));
    assign mag_ovf_c = |(mag_c >> (D_POINT + SQRT_IN_INT));
    assign addr_c    = SQRT_IN_WIDTH'(mag_c >> (D_POINT - SQRT_IN_POINT));

    // Pipeline stages S1..S4 plus the side-band that travels with the S5 LUT read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            s1_b    <= '0;
            s1_c    <= '0;
            s1_tag  <= '0;
            s2_b    <= '0;
            s2_tag  <= '0;
            s2_h2   <= '0;
            s2_cal  <= '0;
            s3_b    <= '0;
            s3_tag  <= '0;
            s3_d    <= '0;
            s4_b    <= '0;
            s4_tag  <= '0;
            s4_addr <= '0;
            s4_neg  <= 1'b0;
            s4_sat  <= 1'b0;
            s5_b    <= '0;
            s5_tag  <= '0;
            s5_neg  <= 1'b0;
            s5_sat  <= 1'b0;
        end else if (en_c) begin
            vld     <= {vld[PIPE_LAT-3:0], din_valid};
            s1_b    <= b;
            s1_c    <= c;
            s1_tag  <= din_tag;
            // h is b reinterpreted with one more fractional bit, so h^2 has point 2*DIN_POINT+2.
            s2_b    <= s1_b;
            s2_tag  <= s1_tag;
            s2_h2   <= H2_WIDTH'(s1_b) * H2_WIDTH'(s1_b);
            s2_cal  <= H2_WIDTH'(s1_c) <<< C_SHIFT;
            s3_b    <= s2_b;
            s3_tag  <= s2_tag;
            s3_d    <= D_WIDTH'(s2_h2) - D_WIDTH'(s2_cal);
            s4_b    <= s3_b;
            s4_tag  <= s3_tag;
            s4_addr <= mag_ovf_c ? '1 : addr_c;
            s4_neg  <= s3_d[D_WIDTH-1];
            s4_sat  <= mag_ovf_c;
            s5_b    <= s4_b;
            s5_tag  <= s4_tag;
            s5_neg  <= s4_neg;
            s5_sat  <= s4_sat;
        end
    end

    // S5: sqrt read, clocked with the rest of the pipeline.
    sqrt_lut_ce #(
        .IN_WIDTH  (SQRT_IN_WIDTH),
        .IN_POINT  (SQRT_IN_POINT),
        .OUT_WIDTH (SQRT_OUT_WIDTH),
        .OUT_POINT (SQRT_OUT_POINT)
    ) u_sqrt (
        .clk  (clk),
        .rst  (rst),
        .ce   (en_c),
        .addr (s4_addr),
        .data (s5_s)
    );

    // -h and s aligned to the output point (truncating) in the sum width.
    assign negh_c = -NEGH_WIDTH'(s5_b);

    if (H_SHIFT >= 0) begin : g_h_rs
        assign negh_al = SUM_WIDTH'(negh_c >>> H_SHIFT);
    end else begin : g_h_ls
        assign negh_al = SUM_WIDTH'(negh_c) <<< (-H_SHIFT);
    end

    if (S_SHIFT >= 0) begin : g_s_ls
        assign s_al = $signed(SUM_WIDTH'(s5_s)) <<< S_SHIFT;
    end else begin : g_s_rs
        assign s_al = $signed(SUM_WIDTH'(s5_s >> (-S_SHIFT)));
    end

    assign sum_p = negh_al + s_al;
    assign sum_m = negh_al - s_al;

    // Root selection and saturation to DOUT_WIDTH.
    always_comb begin
        h_i    = int'(negh_al);
        s_i    = int'(s_al);
        p_i    = int'(sum_p);
        m_i    = int'(sum_m);
        h_q    = sat_int(h_i, DOUT_WIDTH);
        s_q    = sat_int(s_i, DOUT_WIDTH);
        p_q    = sat_int(p_i, DOUT_WIDTH);
        m_q    = sat_int(m_i, DOUT_WIDTH);
        x1_c   = DOUT_WIDTH'(p_q);
        x2_c   = DOUT_WIDTH'(m_q);
        xi_c   = '0;
        clip_c = (p_q != p_i) || (m_q != m_i);
        if (s5_neg) begin
            x1_c   = DOUT_WIDTH'(h_q);
            x2_c   = DOUT_WIDTH'(h_q);
            xi_c   = DOUT_WIDTH'(s_q);
            clip_c = (h_q != h_i) || (s_q != s_i);
        end
    end

    // S6: output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid   <= 1'b0;
            x1           <= '0;
            x2           <= '0;
            x_imag       <= '0;
            dout_tag     <= '0;
            dout_complex <= 1'b0;
            dout_sat     <= 1'b0;
        end else if (en_c) begin
            dout_valid   <= vld[PIPE_LAT-2];
            x1           <= x1_c;
            x2           <= x2_c;
            x_imag       <= xi_c;
            dout_tag     <= s5_tag;
            dout_complex <= s5_neg;
            dout_sat     <= s5_sat | clip_c;
        end
    end

endmodule

// File: tb/tb_quad_root_stream.sv
// Directed self-checking bench for quad_root_stream (default build plus an 8-bit-output build).
module tb_quad_root_stream;
    import quad_pkg::*;

    logic               clk;
    logic               rst;
    logic signed [15:0] b, c;
    logic [3:0]         din_tag;
    logic               din_valid, din_ready, dout_ready;
    logic signed [9:0]  x1, x2, x_imag;
    logic [3:0]         dout_tag;
    logic               dout_complex, dout_sat, dout_valid;

    logic               din_ready_8;
    logic signed [7:0]  x1_8, x2_8, x_imag_8;
    logic [3:0]         dout_tag_8;
    logic               dout_complex_8, dout_sat_8, dout_valid_8;

    int checks = 0;
    int passes = 0;

    // Stall-test vectors: b = -2048*k, c = 0, tag = k.
    int exp_x1 [8] = '{0, 4, 16, 22, 32, 38, 48, 54};
    int exp_x2 [8] = '{0, 4, 0, 2, 0, 2, 0, 2};

    quad_root_stream dut (
        .clk(clk), .rst(rst), .b(b), .c(c), .din_tag(din_tag),
        .din_valid(din_valid), .din_ready(din_ready),
        .x1(x1), .x2(x2), .x_imag(x_imag), .dout_tag(dout_tag),
        .dout_complex(dout_complex), .dout_sat(dout_sat),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    quad_root_stream #(.DOUT_WIDTH(8), .DOUT_POINT(6)) dut8 (
        .clk(clk), .rst(rst), .b(b), .c(c), .din_tag(din_tag),
        .din_valid(din_valid), .din_ready(din_ready_8),
        .x1(x1_8), .x2(x2_8), .x_imag(x_imag_8), .dout_tag(dout_tag_8),
        .dout_complex(dout_complex_8), .dout_sat(dout_sat_8),
        .dout_valid(dout_valid_8), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    endtask

    // Send one sample with dout_ready high and check it appears exactly PIPE_LAT cycles later.
    task automatic run_sample(input string name, input int bv, input int cv, input int tv,
                              input int e1, input int e2, input int ei,
                              input int ecx, input int esat);
        b          = 16'(bv);
        c          = 16'(cv);
        din_tag    = 4'(tv);
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (PIPE_LAT - 2) tick();
        check({name, ".early"}, dout_valid, 0);
        tick();
        check({name, ".valid"},   dout_valid,   1);
        check({name, ".x1"},      x1,           e1);
        check({name, ".x2"},      x2,           e2);
        check({name, ".x_imag"},  x_imag,       ei);
        check({name, ".complex"}, dout_complex, ecx);
        check({name, ".sat"},     dout_sat,     esat);
        check({name, ".tag"},     dout_tag,     tv);
    endtask

    initial begin
        int  in_idx;
        int  out_idx;
        int  stale;
        logic acc;

        rst        = 1'b1;
        b          = '0;
        c          = '0;
        din_tag    = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (2) tick();
        check("reset.valid", dout_valid, 0);
        check("reset.x1",    x1,         0);
        check("reset.tag",   dout_tag,   0);
        rst = 1'b0;
        tick();
        check("reset.din_ready", din_ready, 1);

        // D = 0: double root at -h = 0.5.
        run_sample("d_zero", -16384, 4096, 3, 32, 32, 0, 0, 0);
        // D = 0.0625, s = 0.25.
        run_sample("real", -24576, 8192, 1, 64, 32, 0, 0, 0);
        // D = -1: roots +/- j.
        run_sample("complex", 0, 16384, 5, 0, 0, 64, 1, 0);
        // D = -0.75: -h = -0.5, s = floor(sqrt(0.75)*32)/32 = 27/32.
        run_sample("complex_neg", 16384, 16384, 9, -32, -32, 54, 1, 0);
        // b = -2^15: -h = +1.0, D = 0.
        run_sample("b_min", -32768, 16384, 15, 64, 64, 0, 0, 0);
        // Large positive root: fits 10 bits, clips to 127 in the 8-bit build.
        run_sample("clip", -32604, -32604, 2, 173, -47, 0, 0, 0);
        check("clip8.valid", dout_valid_8, 1);
        check("clip8.x1",    x1_8,         127);
        check("clip8.x2",    x2_8,         -47);
        check("clip8.x_imag", x_imag_8,    0);
        check("clip8.sat",   dout_sat_8,   1);
        tick();

        // Back-to-back burst against a stalled then toggling sink.
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 200 && out_idx < 8; cyc++) begin
            dout_ready = (cyc < 10) ? 1'b0 : 1'(cyc % 2);
            if (in_idx < 8) begin
                b         = 16'(-2048 * in_idx);
                c         = '0;
                din_tag   = 4'(in_idx);
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            #1;
            if (cyc == 8) begin
                check("stall.din_ready", din_ready, 0);
            end
            if (dout_valid && out_idx < 8) begin
                if (dout_ready) begin
                    check("burst.x1",  x1,       exp_x1[out_idx]);
                    check("burst.x2",  x2,       exp_x2[out_idx]);
                    check("burst.tag", dout_tag, out_idx);
                    out_idx++;
                end else begin
                    check("hold.x1",  x1,       exp_x1[out_idx]);
                    check("hold.tag", dout_tag, out_idx);
                end
            end
            acc = din_valid && din_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_idx++;
            end
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        check("burst.count", out_idx, 8);
        repeat (3) tick();

        // Reset with one sample at the output and three in flight.
        for (int k = 1; k <= 4; k++) begin
            b         = 16'(-2048 * k);
            c         = '0;
            din_tag   = 4'(k);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        repeat (2) tick();
        check("pre_rst.valid", dout_valid, 1);
        check("pre_rst.x1",    x1,         4);
        check("pre_rst.tag",   dout_tag,   1);
        rst = 1'b1;
        #1;
        check("mid_rst.valid", dout_valid, 0);
        check("mid_rst.x1",    x1,         0);
        tick();
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dout_valid) begin
                stale++;
            end
        end
        check("post_rst.stale", stale, 0);
        run_sample("after_rst", -24576, 8192, 6, 64, 32, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
